// File: rtl/rename_pkg.sv
// rename_pkg: shared rename-stage types, lane widths and lane-counting helper.
package rename_pkg;
  localparam int PRN_BITS = 6;
  localparam int ARN_COUNT = 32;
  localparam int ALLOC_WIDTH = 2;
  localparam int FREE_WIDTH = 3;
  typedef logic [PRN_BITS-1:0] prn_t;
  function automatic int count_below(input logic [31:0] v, input int k);
    count_below = 0;
    for (int i = 0; i < 32; i++) if (i < k && v[i]) count_below++;
  endfunction
endpackage

// File: rtl/lane_compactor.sv
// lane_compactor: maps sparse valid lanes to dense offsets (number of valid lanes below each lane).
module lane_compactor import rename_pkg::*; #(
  parameter int N = 2,
  parameter int OW = $clog2(N + 1)
) (
  input  logic [N-1:0]         i_valid,
  output logic [N-1:0][OW-1:0] o_off,
  output logic [OW-1:0]        o_total
);
  always_comb begin
    for (int k = 0; k < N; k++) o_off[k] = OW'(count_below(32'(i_valid), k));
    o_total = OW'(count_below(32'(i_valid), N));
  end
endmodule

// File: rtl/prn_free_list.sv
// prn_free_list: circular FIFO of unmapped PRNs with compacted alloc/free lanes and a shadow allocated-bit check.
module prn_free_list #(
  parameter int PRN_BITS = rename_pkg::PRN_BITS,
  parameter int ARN_COUNT = rename_pkg::ARN_COUNT,
  parameter int ALLOC_WIDTH = rename_pkg::ALLOC_WIDTH,
  parameter int FREE_WIDTH = rename_pkg::FREE_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ALLOC_WIDTH-1:0]               alloc_req,
  output logic                                 alloc_ready,
  output logic [ALLOC_WIDTH-1:0][PRN_BITS-1:0] alloc_prn,
  input  logic [FREE_WIDTH-1:0]                free_valid,
  input  logic [FREE_WIDTH-1:0][PRN_BITS-1:0]  free_prn,
  output logic [PRN_BITS:0]                    free_count,
  output logic                                 error
);
  localparam int CAP = 1 << PRN_BITS;
  localparam int CW = PRN_BITS + 1;
  localparam int AOW = $clog2(ALLOC_WIDTH + 1);
  localparam int FOW = $clog2(FREE_WIDTH + 1);
  logic [PRN_BITS-1:0] r_entry [CAP];
  logic [PRN_BITS-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic [CAP-1:0] r_alloc_bits;
  logic r_error;
  logic [ALLOC_WIDTH-1:0][AOW-1:0] w_aoff;
  logic [AOW-1:0] w_nreq;
  logic [FREE_WIDTH-1:0] w_fok, w_facc;
  logic [FREE_WIDTH-1:0][FOW-1:0] w_foff;
  logic [FOW-1:0] w_ftot;
  logic [CW-1:0] w_base, w_room, w_nfree;
  logic w_fire;
  lane_compactor #(.N(ALLOC_WIDTH)) u_alloc (.i_valid(alloc_req), .o_off(w_aoff), .o_total(w_nreq));
  lane_compactor #(.N(FREE_WIDTH)) u_free (.i_valid(w_fok), .o_off(w_foff), .o_total(w_ftot));
  // Grant path looks only at registered state and alloc_req, never at free inputs.
  always_comb begin
    alloc_ready = r_count >= CW'(w_nreq);
    w_fire = alloc_ready && w_nreq != '0;
    for (int k = 0; k < ALLOC_WIDTH; k++) alloc_prn[k] = r_entry[r_head + PRN_BITS'(w_aoff[k])];
  end
  // A free is a candidate only if the PRN is allocated and no earlier valid lane carries it.
  always_comb begin
    w_fok = '0;
    for (int j = 0; j < FREE_WIDTH; j++) begin
      w_fok[j] = free_valid[j] && r_alloc_bits[free_prn[j]];
      for (int i = 0; i < j; i++) if (free_valid[i] && free_prn[i] == free_prn[j]) w_fok[j] = 1'b0;
    end
  end
  always_comb begin
    w_base = r_count - (w_fire ? CW'(w_nreq) : '0);
    w_room = CW'(CAP) - w_base;
    for (int j = 0; j < FREE_WIDTH; j++) w_facc[j] = w_fok[j] && CW'(w_foff[j]) < w_room;
    w_nfree = CW'(w_ftot) < w_room ? CW'(w_ftot) : w_room;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CAP; i++) r_entry[i] <= PRN_BITS'(ARN_COUNT + i);
      for (int p = 0; p < CAP; p++) r_alloc_bits[p] <= p < ARN_COUNT;
      r_head <= '0;
      r_tail <= PRN_BITS'(CAP - ARN_COUNT);
      r_count <= CW'(CAP - ARN_COUNT);
      r_error <= 1'b0;
    end else begin
      for (int j = 0; j < FREE_WIDTH; j++) if (w_facc[j]) r_entry[r_tail + PRN_BITS'(w_foff[j])] <= free_prn[j];
      for (int j = 0; j < FREE_WIDTH; j++) if (w_facc[j]) r_alloc_bits[free_prn[j]] <= 1'b0;
      for (int k = 0; k < ALLOC_WIDTH; k++) if (w_fire && alloc_req[k]) r_alloc_bits[alloc_prn[k]] <= 1'b1;
      r_head <= r_head + (w_fire ? PRN_BITS'(w_nreq) : '0);
      r_tail <= r_tail + PRN_BITS'(w_nfree);
      r_count <= w_base + w_nfree;
      r_error <= r_error || (free_valid != w_facc);
    end
  end
  assign free_count = r_count;
  assign error = r_error;
endmodule

// File: tb/tb_prn_free_list.sv
// tb_prn_free_list: directed steps against a queue scoreboard of free PRNs and a shadow allocated map.
module tb_prn_free_list;
  logic clk, rst;
  logic [1:0] alloc_req;
  logic alloc_ready;
  logic [1:0][5:0] alloc_prn;
  logic [2:0] free_valid;
  logic [2:0][5:0] free_prn;
  logic [6:0] free_count;
  logic error;
  int checks = 0, failures = 0;
  int q[$];
  bit m_alloc[64];
  bit m_err;
  int m_head;

  prn_free_list dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_prn(alloc_prn),
    .free_valid(free_valid), .free_prn(free_prn), .free_count(free_count), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 32; i < 64; i++) q.push_back(i);
    for (int i = 0; i < 64; i++) m_alloc[i] = i < 32;
    m_err = 1'b0;
    m_head = 0;
  endtask

  task automatic step(input bit r, input logic [1:0] req, input logic [2:0] fv, input int p0, input int p1, input int p2);
    int fp[3] = '{p0, p1, p2};
    int granted[$];
    bit seen[64];
    bit ready;
    int e;
    @(negedge clk);
    rst = r; alloc_req = req; free_valid = fv;
    free_prn[0] = 6'(p0); free_prn[1] = 6'(p1); free_prn[2] = 6'(p2);
    #1;
    ready = q.size() >= $countones(req);
    check("alloc_ready", 32'(alloc_ready), 32'(ready));
    if (ready) for (int k = 0; k < 2; k++) if (req[k]) begin
      e = q.pop_front();
      check("alloc_prn", 32'(alloc_prn[k]), e);
      granted.push_back(e);
      m_head++;
    end
    for (int j = 0; j < 3; j++) if (fv[j]) begin
      if (seen[fp[j]] || !m_alloc[fp[j]] || q.size() >= 64) m_err = 1'b1;
      else begin
        q.push_back(fp[j]);
        m_alloc[fp[j]] = 1'b0;
      end
      seen[fp[j]] = 1'b1;
    end
    foreach (granted[i]) m_alloc[granted[i]] = 1'b1;
    if (r) model_reset();
    @(posedge clk);
    #1;
    check("free_count", 32'(free_count), q.size());
    check("error", 32'(error), 32'(m_err));
  endtask

  initial begin
    int nxt, need, ra, nf;
    rst = 1'b1; alloc_req = '0; free_valid = '0; free_prn = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("reset_count", 32'(free_count), 32);
    check("reset_error", 32'(error), 0);
    repeat (16) step(0, 2'b11, 3'b000, 0, 0, 0);
    step(0, 2'b11, 3'b000, 0, 0, 0);
    step(0, 2'b10, 3'b000, 0, 0, 0);
    step(0, 2'b11, 3'b101, 40, 0, 35);
    step(0, 2'b11, 3'b000, 0, 0, 0);
    step(0, 2'b00, 3'b001, 44, 0, 0);
    step(0, 2'b11, 3'b000, 0, 0, 0);
    step(0, 2'b10, 3'b000, 0, 0, 0);
    nxt = 0;
    for (int it = 0; it < 40 && !(m_head == 62 && q.size() == 5); it++) begin
      need = 62 - m_head;
      ra = need < 2 ? need : 2;
      ra = q.size() < ra ? q.size() : ra;
      nf = 5 - (q.size() - ra);
      nf = nf > 3 ? 3 : nf < 0 ? 0 : nf;
      nf = nf > 32 - nxt ? 32 - nxt : nf;
      step(0, ra == 2 ? 2'b11 : ra == 1 ? 2'b01 : 2'b00,
           nf == 3 ? 3'b111 : nf == 2 ? 3'b011 : nf == 1 ? 3'b001 : 3'b000, nxt, nxt + 1, nxt + 2);
      nxt += nf;
    end
    step(0, 2'b11, 3'b111, 32, 33, 34);
    repeat (3) step(0, 2'b11, 3'b000, 0, 0, 0);
    step(0, 2'b00, 3'b001, 50, 0, 0);
    step(0, 2'b00, 3'b010, 0, 50, 0);
    step(1, 2'b00, 3'b000, 0, 0, 0);
    step(0, 2'b11, 3'b000, 0, 0, 0);
    step(0, 2'b00, 3'b011, 33, 33, 0);
    repeat (2) step(0, 2'b00, 3'b000, 0, 0, 0);
    step(1, 2'b11, 3'b001, 32, 0, 0);
    step(0, 2'b11, 3'b000, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prn_free_list.md
# prn_free_list

Physical-register free list that sits between the reorder buffer's retire port and the renamer. It holds every currently unmapped PRN in a circular FIFO. It hands up to ALLOC_WIDTH PRNs per cycle to the renamer for new destination mappings, and accepts up to FREE_WIDTH retired PRNs per cycle from the ROB. A shadow allocated-bit vector catches double frees and frees of unallocated registers.

## Interface
- PRN_BITS, 6, physical register number width; list capacity 2^PRN_BITS.
- ARN_COUNT, 32, PRNs 0..ARN_COUNT-1 hold the initial architectural mappings and are not free at reset.
- ALLOC_WIDTH, 2, allocation lanes per cycle.
- FREE_WIDTH, 3, free lanes per cycle; must equal the ROB's MAX_OPERANDS.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- alloc_req[ALLOC_WIDTH]  in  1 each  renamer requests one PRN on this lane.
- alloc_ready  out  1  every asserted alloc_req lane can be served this cycle.
- alloc_prn[ALLOC_WIDTH]  out  PRN_BITS each  PRN granted to each lane; meaningful only on requesting lanes when alloc_ready=1.
- free_valid[FREE_WIDTH]  in  1 each  ROB returns a PRN on this lane.
- free_prn[FREE_WIDTH]  in  PRN_BITS each  PRN being returned.
- free_count  out  PRN_BITS+1  number of entries currently in the list.
- error  out  1  sticky; set on double free, free of a never-allocated PRN, or overflow.

## Operation
**Storage**
- Array of 2^PRN_BITS PRN entries.
- head and tail pointers, each PRN_BITS wide; they wrap naturally.
- count register, PRN_BITS+1 wide.
- alloc_bits vector of 2^PRN_BITS bits.

**Reset**
- entry[i] = ARN_COUNT+i for i < 2^PRN_BITS-ARN_COUNT.
- head=0, tail=2^PRN_BITS-ARN_COUNT (mod capacity), count=2^PRN_BITS-ARN_COUNT.
- alloc_bits[p]=1 for p<ARN_COUNT, 0 otherwise.
- error=0.

**Allocation (compacted, all-or-nothing)**
- n_req = popcount(alloc_req).
- Lane k receives entry[head + number of requesting lanes below k].
- alloc_ready = (count >= n_req); it is 1 when n_req=0.
- Fire condition: alloc_ready && n_req>0. On fire: head += n_req and alloc_bits of the granted PRNs are set.
- When alloc_ready=0, the list does not change and the renamer stalls.

**Free (compacted)**
- Valid lanes are written in lane order at tail, tail+1, and so on.
- tail += n_free and alloc_bits of each freed PRN is cleared.
- A free lane with alloc_bits[prn]=0 sets error and is dropped: no write, not counted.
- Two lanes freeing the same PRN in one cycle: the second and later copies set error and are dropped.

**Count update**
- count_next = count − (fire ? n_req : 0) + n_free_accepted.
- If count_next would exceed 2^PRN_BITS, set error and drop the excess frees.

**Other rules**
- Frees and allocations in the same cycle are independent.
- There is no free→alloc bypass: a freed PRN is allocatable from the next cycle.
- Flush rollback is not handled here. The ROB returns flushed instructions' overwritten PRNs through the normal retire/free path.

## Timing
- alloc_ready and alloc_prn are combinational from registered state and alloc_req. There is no dependence on free_* inputs, so the free path has no comb loop into the renamer.
- All state updates happen on posedge clk. Latency is free → allocatable in 1 cycle.
- Output values in the first cycle after reset, with default parameters: free_count=32, alloc_prn lanes = 32 and 33 (both requesting), alloc_ready=1, error=0.
- Empty boundary: with count=1 and both lanes requesting, alloc_ready=0 and nothing is consumed. With only lane 1 requesting, lane 1 receives entry[head].
- Wrap-around: pointers wrap at 2^PRN_BITS with no bubble.
- rst asserted mid-operation restores the full reset image on the next edge; in-flight frees that cycle are discarded.

## Structure
- Shared package rename_pkg:
  - prn_t typedef (logic [PRN_BITS-1:0]).
  - ALLOC_WIDTH and FREE_WIDTH constants.
  - popcount/prefix-count function, also reused by the renamer.
- A single sub-module, lane_compactor, maps sparse valid lanes to dense offsets. It is instantiated twice: once for allocation, once for free.

## Test plan
- **Reset image:** assert rst 1 cycle, then idle → free_count=32, error=0; with both lanes requesting, alloc_prn={32,33} and alloc_ready=1.
- **Drain and stall:** request 2 per cycle for 16 cycles → PRNs 32..63 issued in order and free_count=0. A 17th request gets alloc_ready=0 and the state does not change.
- **Free and reuse:** with the list empty, free lanes {0:40, 2:35} → next cycle free_count=2 and alloc_prn={40,35}. There is no bypass in the same cycle.
- **Simultaneous alloc+free across wrap:** hold count=5 with head at 62; allocate 2 and free 3 in one cycle → head=0, count=6, FIFO order preserved across the wrap.
- **Error detection:**
  - Free PRN 50 while it is unallocated → error=1 and count unchanged.
  - Free PRN 33 on two lanes in one cycle → count+1, error=1, and error stays set until rst.
- **Mid-run reset:** rst during a cycle with both allocation and free active → next cycle matches the reset image exactly.
